id_ex_stage: RTL and testbench

- Parametrised decode stage for the 5-stage MIPS pipeline. It contains the register file, main control decode, immediate extension and the ID/EX pipeline register.
- It adds a valid bit, load-use hazard detection with a stall/bubble, branch flush, and write-first bypass for same-cycle writeback.
- Sits between the IF/ID latch and the EX stage. The stall output drives the PC and IF/ID hold enables.

---
 rtl/id_ex_stage_pkg.sv | 39 +++
 rtl/id_ex_stage_if.sv | 29 ++
 rtl/id_ex_stage_regfile.sv | 39 +++
 rtl/id_ex_stage.sv | 92 +++++++++
 tb/tb_id_ex_stage.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared decode constants for the ID/EX stage: opcodes, control field
// widths, per-opcode control words and the all-zero bubble word.
package id_pkg;

    localparam int WB_W = 2;
    localparam int M_W  = 3;
    localparam int EX_W = 4;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    // wb = {RegWrite, MemtoReg}, m = {Branch, MemRead, MemWrite},
    // ex = {RegDst, ALUOp[1:0], ALUSrc}
    typedef struct packed {
        logic [WB_W-1:0] wb;
        logic [M_W-1:0]  m;
        logic [EX_W-1:0] ex;
    } ctrl_t;

    localparam ctrl_t CTRL_RTYPE  = '{wb: 2'b10, m: 3'b000, ex: 4'b1100};
    localparam ctrl_t CTRL_LW     = '{wb: 2'b11, m: 3'b010, ex: 4'b0001};
    localparam ctrl_t CTRL_SW     = '{wb: 2'b00, m: 3'b001, ex: 4'b0001};
    localparam ctrl_t CTRL_BEQ    = '{wb: 2'b00, m: 3'b100, ex: 4'b0010};
    localparam ctrl_t CTRL_BUBBLE = '{wb: 2'b00, m: 3'b000, ex: 4'b0000};

    // Unknown opcodes decode as a nop
    function automatic ctrl_t decode_op(input logic [5:0] op);
        case (op)
            OP_RTYPE: return CTRL_RTYPE;
            OP_LW:    return CTRL_LW;
            OP_SW:    return CTRL_SW;
            OP_BEQ:   return CTRL_BEQ;
            default:  return CTRL_BUBBLE;
        endcase
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// ID/EX pipeline register bus. The decode stage drives it (master),
// the execute stage consumes it (slave).
interface id_ex_if
    import id_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
);
    logic              ex_valid;
    logic [WB_W-1:0]   ex_wb;
    logic [M_W-1:0]    ex_m;
    logic [EX_W-1:0]   ex_ctrl;
    logic [DATA_W-1:0] ex_npc;
    logic [DATA_W-1:0] ex_rd1;
    logic [DATA_W-1:0] ex_rd2;
    logic [DATA_W-1:0] ex_imm;
    logic [REG_AW-1:0] ex_rt;
    logic [REG_AW-1:0] ex_rd;

    modport master (
        output ex_valid, ex_wb, ex_m, ex_ctrl,
        output ex_npc, ex_rd1, ex_rd2, ex_imm, ex_rt, ex_rd
    );

    modport slave (
        input ex_valid, ex_wb, ex_m, ex_ctrl,
        input ex_npc, ex_rd1, ex_rd2, ex_imm, ex_rt, ex_rd
    );
endinterface

// File: rtl/id_ex_stage_regfile.sv
// Register file: two combinational read ports, one write port,
// write-first bypass, r0 hardwired to zero, synchronous clear.
module id_regfile #(
    parameter int DATA_W = 32,
    parameter int NREG   = 32,
    localparam int REG_AW = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] ra1,
    input  logic [REG_AW-1:0] ra2,
    input  logic              we,
    input  logic [REG_AW-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2
);
    logic [DATA_W-1:0] mem [NREG];
    logic              wr_live;

    assign wr_live = we && (wa != '0);

    // Storage update; writes to r0 are dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) mem[i] <= '0;
        end else if (wr_live) begin
            mem[wa] <= wd;
        end
    end

    // Read ports, forwarding same-cycle writeback data
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (ra1 != '0) rd1 = (wr_live && wa == ra1) ? wd : mem[ra1];
        if (ra2 != '0) rd2 = (wr_live && wa == ra2) ? wd : mem[ra2];
    end
endmodule

// File: rtl/id_ex_stage.sv
// MIPS decode stage: register file, control decode, immediate extension,
// load-use hazard stall, branch flush and the ID/EX pipeline register.
// Optional: define ID_PERF_CNT_EN to add the saturating stall_cnt output.
module id_ex_stage
    import id_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NREG   = 32,
    localparam int REG_AW = $clog2(NREG),
    parameter int IMM_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       instr_in,
    input  logic [DATA_W-1:0] npc_in,
    input  logic              id_valid_in,
    input  logic              flush,
    input  logic              reg_write_wb,
    input  logic [REG_AW-1:0] wr_addr_wb,
    input  logic [DATA_W-1:0] wr_data_wb,
    output logic              stall_out,
`ifdef ID_PERF_CNT_EN
    output logic [31:0]       stall_cnt,
`endif
    id_ex_if.master           ex
);
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] imm;
    logic              hazard;
    ctrl_t             dec;

    assign rs  = instr_in[21 +: REG_AW];
    assign rt  = instr_in[16 +: REG_AW];
    assign rd  = instr_in[11 +: REG_AW];
    assign imm = {{(DATA_W-IMM_W){instr_in[IMM_W-1]}}, instr_in[IMM_W-1:0]};
    assign dec = decode_op(instr_in[31:26]);

    // Conservative: an rt match stalls even if the instruction ignores rt
    assign hazard = id_valid_in & ex.ex_valid & ex.ex_m[1] & (ex.ex_rt != '0)
                  & ((ex.ex_rt == rs) | (ex.ex_rt == rt));
    assign stall_out = hazard & ~flush & ~rst;

    id_regfile #(.DATA_W(DATA_W), .NREG(NREG)) u_regfile (
        .clk (clk),
        .rst (rst),
        .ra1 (rs),
        .ra2 (rt),
        .we  (reg_write_wb),
        .wa  (wr_addr_wb),
        .wd  (wr_data_wb),
        .rd1 (rd1),
        .rd2 (rd2)
    );

    // ID/EX register: reset and bubble both load all zeros
    always_ff @(posedge clk) begin
        if (rst || flush || hazard) begin
            ex.ex_valid <= 1'b0;
            {ex.ex_wb, ex.ex_m, ex.ex_ctrl} <= CTRL_BUBBLE;
            ex.ex_npc <= '0;
            ex.ex_rd1 <= '0;
            ex.ex_rd2 <= '0;
            ex.ex_imm <= '0;
            ex.ex_rt  <= '0;
            ex.ex_rd  <= '0;
        end else begin
            ex.ex_valid <= id_valid_in;
            {ex.ex_wb, ex.ex_m, ex.ex_ctrl} <= id_valid_in ? dec : CTRL_BUBBLE;
            ex.ex_npc <= npc_in;
            ex.ex_rd1 <= rd1;
            ex.ex_rd2 <= rd2;
            ex.ex_imm <= imm;
            ex.ex_rt  <= rt;
            ex.ex_rd  <= rd;
        end
    end

`ifdef ID_PERF_CNT_EN
    // Saturating count of stalled cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall_out && stall_cnt != 32'hFFFF_FFFF) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed, table-driven bench for id_ex_stage.
module tb_id_ex_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr_in;
    logic [31:0] npc_in;
    logic        id_valid_in;
    logic        flush;
    logic        reg_write_wb;
    logic [4:0]  wr_addr_wb;
    logic [31:0] wr_data_wb;
    logic        stall_out;
`ifdef ID_PERF_CNT_EN
    logic [31:0] stall_cnt;
`endif

    id_ex_if #(.DATA_W(32), .REG_AW(5)) ex_bus ();

    id_ex_stage dut (
        .clk          (clk),
        .rst          (rst),
        .instr_in     (instr_in),
        .npc_in       (npc_in),
        .id_valid_in  (id_valid_in),
        .flush        (flush),
        .reg_write_wb (reg_write_wb),
        .wr_addr_wb   (wr_addr_wb),
        .wr_data_wb   (wr_data_wb),
        .stall_out    (stall_out),
`ifdef ID_PERF_CNT_EN
        .stall_cnt    (stall_cnt),
`endif
        .ex           (ex_bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic        valid;
        logic        fl;
        logic        rw;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        stall;
        logic        evalid;
        logic [1:0]  wb;
        logic [2:0]  m;
        logic [3:0]  ctrl;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [4:0]  rt;
        logic [4:0]  rd;
    } vec_t;

    localparam int NVEC = 17;
    vec_t vecs [NVEC];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_ex(input string tag, input logic ev, input logic [1:0] wb,
                          input logic [2:0] m, input logic [3:0] ctrl, input logic [31:0] npc,
                          input logic [31:0] rd1, input logic [31:0] rd2, input logic [31:0] imm,
                          input logic [4:0] rt, input logic [4:0] rd);
        chk({tag, ".ex_valid"}, {31'd0, ex_bus.ex_valid}, {31'd0, ev});
        chk({tag, ".ex_wb"},    {30'd0, ex_bus.ex_wb},    {30'd0, wb});
        chk({tag, ".ex_m"},     {29'd0, ex_bus.ex_m},     {29'd0, m});
        chk({tag, ".ex_ctrl"},  {28'd0, ex_bus.ex_ctrl},  {28'd0, ctrl});
        chk({tag, ".ex_npc"},   ex_bus.ex_npc, npc);
        chk({tag, ".ex_rd1"},   ex_bus.ex_rd1, rd1);
        chk({tag, ".ex_rd2"},   ex_bus.ex_rd2, rd2);
        chk({tag, ".ex_imm"},   ex_bus.ex_imm, imm);
        chk({tag, ".ex_rt"},    {27'd0, ex_bus.ex_rt}, {27'd0, rt});
        chk({tag, ".ex_rd"},    {27'd0, ex_bus.ex_rd}, {27'd0, rd});
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] npc, input logic v,
                         input logic fl, input logic rw, input logic [4:0] wa, input logic [31:0] wd);
        instr_in     = instr;
        npc_in       = npc;
        id_valid_in  = v;
        flush        = fl;
        reg_write_wb = rw;
        wr_addr_wb   = wa;
        wr_data_wb   = wd;
    endtask

    initial begin
        logic [31:0] npc;
        logic        bub;

        //               instr         v     fl    rw    wa     wd            st    ev    wb     m       ctrl     rd1           rd2           imm           rt     rd
        vecs[0]  = '{32'h00A01820, 1'b1, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b1, 2'b10, 3'b000, 4'b1100, 32'hDEADBEEF, 32'h0,        32'h00001820, 5'd0, 5'd3};
        vecs[1]  = '{32'h00000020, 1'b1, 1'b0, 1'b1, 5'd0, 32'h00001234, 1'b0, 1'b1, 2'b10, 3'b000, 4'b1100, 32'h0,        32'h0,        32'h00000020, 5'd0, 5'd0};
        vecs[2]  = '{32'h00A00820, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 1'b1, 2'b10, 3'b000, 4'b1100, 32'hDEADBEEF, 32'h0,        32'h00000820, 5'd0, 5'd1};
        vecs[3]  = '{32'h8D280004, 1'b1, 1'b0, 1'b1, 5'd9, 32'h00001000, 1'b0, 1'b1, 2'b11, 3'b010, 4'b0001, 32'h00001000, 32'h0,        32'h00000004, 5'd8, 5'd0};
        vecs[4]  = '{32'h01085020, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 2'b00, 3'b000, 4'b0000, 32'h0,        32'h0,        32'h0,        5'd0, 5'd0};
        vecs[5]  = '{32'h01085020, 1'b1, 1'b0, 1'b1, 5'd8, 32'h00000055, 1'b0, 1'b1, 2'b10, 3'b000, 4'b1100, 32'h00000055, 32'h00000055, 32'h00005020, 5'd8, 5'd10};
        vecs[6]  = '{32'hAD28FFFC, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 1'b1, 2'b00, 3'b001, 4'b0001, 32'h00001000, 32'h00000055, 32'hFFFFFFFC, 5'd8, 5'd31};
        vecs[7]  = '{32'h11090003, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 1'b1, 2'b00, 3'b100, 4'b0010, 32'h00000055, 32'h00001000, 32'h00000003, 5'd9, 5'd0};
        vecs[8]  = '{32'h3508000F, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 1'b1, 2'b00, 3'b000, 4'b0000, 32'h00000055, 32'h00000055, 32'h0000000F, 5'd8, 5'd0};
        vecs[9]  = '{32'h00A01820, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 2'b00, 3'b000, 4'b0000, 32'hDEADBEEF, 32'h0,        32'h00001820, 5'd0, 5'd3};
        vecs[10] = '{32'h8D280004, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 1'b1, 2'b11, 3'b010, 4'b0001, 32'h00001000, 32'h00000055, 32'h00000004, 5'd8, 5'd0};
        vecs[11] = '{32'h01085020, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 2'b00, 3'b000, 4'b0000, 32'h0,        32'h0,        32'h0,        5'd0, 5'd0};
        vecs[12] = '{32'h8D280004, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 1'b1, 2'b11, 3'b010, 4'b0001, 32'h00001000, 32'h00000055, 32'h00000004, 5'd8, 5'd0};
        vecs[13] = '{32'h8D280004, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 2'b00, 3'b000, 4'b0000, 32'h0,        32'h0,        32'h0,        5'd0, 5'd0};
        vecs[14] = '{32'h8D280004, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 1'b1, 2'b11, 3'b010, 4'b0001, 32'h00001000, 32'h00000055, 32'h00000004, 5'd8, 5'd0};
        vecs[15] = '{32'h01085020, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 2'b00, 3'b000, 4'b0000, 32'h0,        32'h0,        32'h0,        5'd0, 5'd0};
        vecs[16] = '{32'h01085020, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 1'b1, 2'b10, 3'b000, 4'b1100, 32'h00000055, 32'h00000055, 32'h00005020, 5'd8, 5'd10};

        // Reset for two cycles under random inputs
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            drive($urandom, $urandom, 1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom), $urandom);
            #1 chk("rst.stall_out", {31'd0, stall_out}, 32'd0);
        end
        @(posedge clk); #1;
        chk_ex("rst", 1'b0, 2'b00, 3'b000, 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0);
`ifdef ID_PERF_CNT_EN
        chk("rst.stall_cnt", stall_cnt, 32'd0);
`endif
        // Registers read back as zero after reset
        @(negedge clk);
        rst = 1'b0;
        drive(32'h01285020, 32'h0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        @(posedge clk); #1;
        chk("rst.read_r9", ex_bus.ex_rd1, 32'h0);
        chk("rst.read_r8", ex_bus.ex_rd2, 32'h0);

        // Table: each row is one clock of ID inputs and the ID/EX result
        for (int i = 0; i < NVEC; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            npc = 32'h100 + 32'(4 * i);
            bub = vecs[i].stall | vecs[i].fl;
            @(negedge clk);
            drive(vecs[i].instr, npc, vecs[i].valid, vecs[i].fl, vecs[i].rw, vecs[i].wa, vecs[i].wd);
            #1 chk({tag, ".stall_out"}, {31'd0, stall_out}, {31'd0, vecs[i].stall});
            @(posedge clk); #1;
            chk_ex(tag, vecs[i].evalid, vecs[i].wb, vecs[i].m, vecs[i].ctrl,
                   bub ? 32'h0 : npc, vecs[i].rd1, vecs[i].rd2, vecs[i].imm,
                   vecs[i].rt, vecs[i].rd);
        end
`ifdef ID_PERF_CNT_EN
        chk("perf.stall_cnt", stall_cnt, 32'd3);
`endif

        // r0 stays zero in later cycles after the attempted write
        @(negedge clk);
        drive(32'h00000020, 32'h200, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        @(posedge clk); #1;
        chk("r0.later_rd1", ex_bus.ex_rd1, 32'h0);
        chk("r0.later_rd2", ex_bus.ex_rd2, 32'h0);

        // Reset arriving while a load-use stall is pending
        @(negedge clk);
        drive(32'h8D280004, 32'h204, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        @(posedge clk); #1;
        chk("midrst.lw_m", {29'd0, ex_bus.ex_m}, 32'd2);
        @(negedge clk);
        drive(32'h01085020, 32'h208, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        #1 chk("midrst.pre_stall", {31'd0, stall_out}, 32'd1);
        rst = 1'b1;
        #1 chk("midrst.stall_out", {31'd0, stall_out}, 32'd0);
        @(posedge clk); #1;
        chk_ex("midrst", 1'b0, 2'b00, 3'b000, 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0);
`ifdef ID_PERF_CNT_EN
        chk("midrst.stall_cnt", stall_cnt, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        drive(32'h01085020, 32'h20C, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        #1 chk("midrst.no_stall", {31'd0, stall_out}, 32'd0);
        @(posedge clk); #1;
        chk_ex("midrst.after", 1'b1, 2'b10, 3'b000, 4'b1100, 32'h20C, 32'h0, 32'h0, 32'h00005020, 5'd8, 5'd10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
